// File: rtl/ysyx_23060208_axi_pkg.sv
// Shared AXI-lite definitions: response codes and read-arbiter state encodings.
package ysyx_23060208_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_ERR   = 3'd3,
      ST_DRAIN = 3'd4
   } arb_state_e;

endpackage

// File: rtl/ysyx_23060208_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R). The master drives the request side and the slave drives the response side.
interface ysyx_23060208_rd_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
   modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/ysyx_23060208_rr_pick.sv
// Two-way round-robin pick. On a tie the master that was not served last wins.
module ysyx_23060208_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);
   assign grant = (&req) ? ~last : req[1];
endmodule

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Round-robin read arbiter for IFU (m0) and LSU (m1) on one AXI-lite read slave.
// The grant stays locked from AR to R, and a watchdog answers SLVERR for a response that never arrives.
module ysyx_23060208_rd_arbiter
   import ysyx_23060208_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_23060208_rd_arbiter_if.slave         m0,
   ysyx_23060208_rd_arbiter_if.slave         m1,
   ysyx_23060208_rd_arbiter_if.master        s,
   output logic                              grant,
   output logic                              busy,
   output logic                              timeout
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   arb_state_e    state, state_d;
   logic          grant_d, last, last_d, pick;
   logic [CW-1:0] cnt, cnt_d;

   logic                  arvalid_g, rready_g, ar_fire, r_fire;
   logic [ADDR_WIDTH-1:0] araddr_g;
   logic [DATA_WIDTH-1:0] rdata_g;

   ysyx_23060208_rr_pick u_pick (
      .req   ({m1.arvalid, m0.arvalid}),
      .last  (last),
      .grant (pick)
   );

   assign arvalid_g = grant ? m1.arvalid : m0.arvalid;
   assign araddr_g  = grant ? m1.araddr  : m0.araddr;
   assign rready_g  = grant ? m1.rready  : m0.rready;
   assign rdata_g   = (state == ST_DATA) ? s.rdata : '0;
   assign ar_fire   = (state == ST_ADDR) && arvalid_g && s.arready;
   assign r_fire    = (state == ST_DATA) && s.rvalid && rready_g;
   assign busy      = (state != ST_IDLE);

   // NOTE: flops use non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_d;
         grant <= grant_d;
         last  <= last_d;
         cnt   <= cnt_d;
      end
   end

   // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state;
      grant_d = grant;
      last_d  = last;
      cnt_d   = cnt;
      timeout = 1'b0;
      case (state)
         ST_IDLE: if (m0.arvalid || m1.arvalid) begin
            grant_d = pick;
            state_d = ST_ADDR;
         end
         ST_ADDR: if (ar_fire) begin
            cnt_d   = '0;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            if (r_fire) begin
               last_d  = grant;
               state_d = ST_IDLE;
            end else begin
               // Saturating count: once past the firing point it can never wrap back onto it.
               if (cnt != CNT_MAX) cnt_d = cnt + CW'(1);
               if (TIMEOUT != 0 && cnt == CNT_LAST && !s.rvalid) begin
                  timeout = 1'b1;
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR:   if (rready_g) state_d = ST_DRAIN;
         ST_DRAIN: if (s.rvalid) begin
            last_d  = grant;
            state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s.araddr   = '0;
      s.arvalid  = 1'b0;
      s.rready   = 1'b0;
      m0.arready = 1'b0;
      m0.rdata   = '0;
      m0.rresp   = RESP_OKAY;
      m0.rvalid  = 1'b0;
      m1.arready = 1'b0;
      m1.rdata   = '0;
      m1.rresp   = RESP_OKAY;
      m1.rvalid  = 1'b0;
      case (state)
         ST_ADDR: begin
            s.araddr  = araddr_g;
            s.arvalid = arvalid_g;
            if (grant) m1.arready = s.arready;
            else       m0.arready = s.arready;
         end
         ST_DATA: begin
            s.rready = rready_g;
            if (grant) begin
               m1.rdata  = rdata_g;
               m1.rresp  = s.rresp;
               m1.rvalid = s.rvalid;
            end else begin
               m0.rdata  = rdata_g;
               m0.rresp  = s.rresp;
               m0.rvalid = s.rvalid;
            end
         end
         ST_ERR: begin
            if (grant) begin
               m1.rvalid = 1'b1;
               m1.rresp  = RESP_SLVERR;
            end else begin
               m0.rvalid = 1'b1;
               m0.rresp  = RESP_SLVERR;
            end
         end
         // The late slave beat is swallowed here; neither master sees it.
         ST_DRAIN: s.rready = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the two-master read arbiter; the bench plays both masters and the slave.
module tb_ysyx_23060208_rd_arbiter;
   import ysyx_23060208_axi_pkg::*;

   logic clk;
   logic rst;
   logic grant, busy, timeout;

   int checks = 0;
   int errors = 0;
   int n, ar_cnt, k_fire;
   logic exp_g [4];

   ysyx_23060208_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
   ysyx_23060208_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
   ysyx_23060208_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

   ysyx_23060208_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .m0      (m0_bus),
      .m1      (m1_bus),
      .s       (s_bus),
      .grant   (grant),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_time_limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Move to just after the next rising edge; inputs are changed here, outputs read 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_bus.araddr  = '0; m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b0;
      m1_bus.araddr  = '0; m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b0;
      s_bus.arready  = 1'b0; s_bus.rdata = '0; s_bus.rresp = RESP_OKAY; s_bus.rvalid = 1'b0;
   endtask

   initial begin
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
      rst = 1'b0;
      idle_inputs();
      cyc(); cyc();
      #1;
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_timeout", timeout, 0);
      check("rst_s_arvalid", s_bus.arvalid, 0);
      check("rst_s_rready", s_bus.rready, 0);
      check("rst_m0_rvalid", m0_bus.rvalid, 0);
      rst = 1'b1;
      cyc();

      // Continuous tie: round robin from reset must go m0,m1,m0,m1.
      m0_bus.araddr = 32'h0000_1000; m1_bus.araddr = 32'h0000_2000;
      m0_bus.arvalid = 1'b1; m1_bus.arvalid = 1'b1;
      m0_bus.rready = 1'b1; m1_bus.rready = 1'b1;
      s_bus.arready = 1'b1; s_bus.rvalid = 1'b1; s_bus.rdata = 32'hA5A5_0000;
      n = 0; ar_cnt = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         #1;
         if (s_bus.arvalid) ar_cnt++;
         if (s_bus.arvalid && s_bus.arready) begin
            check("t2_grant", grant, exp_g[n]);
            check("t2_araddr", s_bus.araddr, exp_g[n] ? 32'h0000_2000 : 32'h0000_1000);
            n++;
         end
         cyc();
      end
      check("t2_grants_seen", n, 4);
      m0_bus.arvalid = 1'b0; m1_bus.arvalid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (s_bus.arvalid) ar_cnt++;
         cyc();
      end
      check("t2_ar_count", ar_cnt, 4);
      idle_inputs();
      cyc();

      // Single m0 read: arready at cycle 2, rvalid at cycle 4.
      m0_bus.araddr = 32'h8000_0000; m0_bus.arvalid = 1'b1; m0_bus.rready = 1'b1;
      #1 check("t1_c0_busy", busy, 0);
      cyc();
      #1;
      check("t1_c1_s_arvalid", s_bus.arvalid, 1);
      check("t1_c1_s_araddr", s_bus.araddr, 32'h8000_0000);
      check("t1_c1_m0_arready", m0_bus.arready, 0);
      check("t1_c1_grant", grant, 0);
      cyc();
      s_bus.arready = 1'b1;
      #1;
      check("t1_c2_m0_arready", m0_bus.arready, 1);
      check("t1_c2_m1_arready", m1_bus.arready, 0);
      cyc();
      m0_bus.arvalid = 1'b0; s_bus.arready = 1'b0;
      #1;
      check("t1_c3_m0_rvalid", m0_bus.rvalid, 0);
      check("t1_c3_s_rready", s_bus.rready, 1);
      cyc();
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'hDEAD_BEEF; s_bus.rresp = RESP_OKAY;
      #1;
      check("t1_c4_m0_rvalid", m0_bus.rvalid, 1);
      check("t1_c4_m0_rdata", m0_bus.rdata, 32'hDEAD_BEEF);
      check("t1_c4_m0_rresp", m0_bus.rresp, 0);
      check("t1_c4_m1_rvalid", m1_bus.rvalid, 0);
      check("t1_c4_m1_rdata", m1_bus.rdata, 0);
      cyc();
      idle_inputs();
      #1 check("t1_c5_busy", busy, 0);
      cyc();

      // m1 stalls R for 3 cycles while m0 waits for its turn.
      m1_bus.araddr = 32'h0000_3000; m1_bus.arvalid = 1'b1; s_bus.arready = 1'b1;
      cyc();
      m0_bus.araddr = 32'h0000_4000; m0_bus.arvalid = 1'b1; m0_bus.rready = 1'b1;
      #1;
      check("t3_grant_m1", grant, 1);
      check("t3_s_araddr", s_bus.araddr, 32'h0000_3000);
      check("t3_m1_arready", m1_bus.arready, 1);
      check("t3_m0_arready", m0_bus.arready, 0);
      cyc();
      m1_bus.arvalid = 1'b0; s_bus.arready = 1'b0;
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h5555_AAAA;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t3_stall_s_rready", s_bus.rready, 0);
         check("t3_stall_m1_rvalid", m1_bus.rvalid, 1);
         check("t3_stall_m1_rdata", m1_bus.rdata, 32'h5555_AAAA);
         check("t3_stall_m0_rvalid", m0_bus.rvalid, 0);
         check("t3_stall_m0_arready", m0_bus.arready, 0);
         cyc();
      end
      m1_bus.rready = 1'b1;
      #1 check("t3_release_s_rready", s_bus.rready, 1);
      cyc();
      s_bus.rvalid = 1'b0;
      #1;
      check("t3_idle_busy", busy, 0);
      check("t3_idle_grant", grant, 1);
      cyc();
      s_bus.arready = 1'b1;
      #1;
      check("t3_m0_grant", grant, 0);
      check("t3_m0_araddr", s_bus.araddr, 32'h0000_4000);
      cyc();
      m0_bus.arvalid = 1'b0; s_bus.arready = 1'b0;
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0BAD_F00D;
      #1 check("t3_m0_rdata", m0_bus.rdata, 32'h0BAD_F00D);
      cyc();
      idle_inputs();
      cyc();

      // Watchdog: m1 read whose response never arrives.
      m1_bus.araddr = 32'h0000_6000; m1_bus.arvalid = 1'b1; s_bus.arready = 1'b1;
      cyc();
      #1 check("t4_ar_handshake", s_bus.arvalid & s_bus.arready & grant, 1);
      cyc();
      m1_bus.arvalid = 1'b0; s_bus.arready = 1'b0;
      k_fire = -1;
      for (int k = 1; k <= 20 && k_fire < 0; k++) begin
         #1;
         if (timeout) k_fire = k;
         else cyc();
      end
      check("t4_fire_cycle", k_fire, 8);
      cyc();
      #1;
      check("t4_err_timeout_low", timeout, 0);
      check("t4_err_m1_rvalid", m1_bus.rvalid, 1);
      check("t4_err_m1_rresp", m1_bus.rresp, RESP_SLVERR);
      check("t4_err_m1_rdata", m1_bus.rdata, 0);
      check("t4_err_s_rready", s_bus.rready, 0);
      check("t4_err_m0_rvalid", m0_bus.rvalid, 0);
      cyc();
      m1_bus.rready = 1'b1;
      #1 check("t4_err_hold_rvalid", m1_bus.rvalid, 1);
      cyc();
      m1_bus.rready = 1'b0;
      #1;
      check("t4_drain_s_rready", s_bus.rready, 1);
      check("t4_drain_m1_rvalid", m1_bus.rvalid, 0);
      check("t4_drain_busy", busy, 1);

      // Late beat arrives in DRAIN and is discarded.
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0000_1234;
      #1;
      check("t5_m1_rvalid", m1_bus.rvalid, 0);
      check("t5_m1_rdata", m1_bus.rdata, 0);
      check("t5_m0_rvalid", m0_bus.rvalid, 0);
      cyc();
      s_bus.rvalid = 1'b0;
      #1 check("t5_busy_after", busy, 0);
      m0_bus.araddr = 32'h0000_7000; m1_bus.araddr = 32'h0000_8000;
      m0_bus.arvalid = 1'b1; m1_bus.arvalid = 1'b1;
      m0_bus.rready = 1'b1; m1_bus.rready = 1'b1;
      s_bus.arready = 1'b1;
      cyc();
      #1;
      check("t5_next_grant", grant, 0);
      check("t5_next_araddr", s_bus.araddr, 32'h0000_7000);
      cyc();
      m0_bus.arvalid = 1'b0;
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h0000_00AA;
      #1 check("t5_next_rdata", m0_bus.rdata, 32'h0000_00AA);
      cyc();
      s_bus.rvalid = 1'b0;
      cyc();
      #1 check("t6_pre_grant_m1", grant, 1);
      cyc();

      // Reset while m1 is in DATA.
      #1 check("t6_in_data", s_bus.rready, 1);
      rst = 1'b0;
      cyc();
      #1;
      check("t6_busy", busy, 0);
      check("t6_grant", grant, 0);
      check("t6_s_arvalid", s_bus.arvalid, 0);
      check("t6_s_rready", s_bus.rready, 0);
      check("t6_m1_rvalid", m1_bus.rvalid, 0);
      check("t6_m1_arready", m1_bus.arready, 0);
      rst = 1'b1;
      m0_bus.arvalid = 1'b1;
      cyc();
      #1;
      check("t6_tie_grant", grant, 0);
      check("t6_tie_araddr", s_bus.araddr, 32'h0000_7000);
      check("t6_tie_m1_arready", m1_bus.arready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
